// File: rtl/atm_controller_if.sv
// Card/keypad/amount strobe interface between the ATM front-end (master)
// and the atm_controller (slave), including the controller's result indications.
interface atm_controller_if;
    logic        tarjeta_recibida;
    logic        tipo_trans;
    logic        digito_stb;
    logic [3:0]  digito;
    logic        monto_stb;
    logic [31:0] monto;
    logic        balance_actualizado;
    logic        entregar_dinero;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        fondos_insuficientes;

    modport master (
        output tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
        input  balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
        output balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );
endinterface

// File: rtl/atm_controller.sv
// Single-account ATM control FSM: card, 4-digit PIN check with lockout, deposit/withdrawal.
// Optional idle timeout in PIN/amount entry is enabled by defining ATM_TIMEOUT_EN.
module atm_controller #(
    parameter logic [15:0]      PIN          = 16'h4756,
    parameter int               BAL_W        = 64,
`ifdef ATM_TIMEOUT_EN
    parameter int               TIMEOUT_CYC  = 255,
`endif
    parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(64'd5000)
) (
    input  logic               clk,
    input  logic               rst,
    atm_controller_if.slave    bus
);

    typedef enum logic [2:0] {
        ESPERANDO_TARJETA = 3'd0,
        VERIFICAR_PIN     = 3'd1,
        ESPERANDO_MONTO   = 3'd2,
        DEPOSITO          = 3'd3,
        RETIRO            = 3'd4,
        BLOQUEO           = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic               card_q_r, dig_q_r, monto_stb_q_r;
    logic               card_ev_r, dig_ev_r, monto_ev_r;
    logic [3:0]         digito_q_r;
    logic [31:0]        monto_q_r;
    logic               tipo_q_r;
    logic [15:0]        pin_r, pin_s;
    logic [2:0]         cnt_r, cnt_s;
    logic [1:0]         att_r, att_s;
    logic [BAL_W-1:0]   bal_r, bal_s;
    logic [31:0]        monto_l_r, monto_l_s;
    logic               bal_act_r, bal_act_s;
    logic               entregar_r, entregar_s;
    logic               pin_inc_r, pin_inc_s;
    logic               adv_r, adv_s;
    logic               blq_r, blq_s;
    logic               fondos_r, fondos_s;
    logic [BAL_W:0]     sum_s;
    logic [BAL_W-1:0]   monto_ext_s;
`ifdef ATM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]    to_r, to_s;
    logic               progress_s;
`endif

    // Input registers and rising-edge event registers; data is captured alongside its strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            card_q_r      <= 1'b0;
            dig_q_r       <= 1'b0;
            monto_stb_q_r <= 1'b0;
            card_ev_r     <= 1'b0;
            dig_ev_r      <= 1'b0;
            monto_ev_r    <= 1'b0;
            digito_q_r    <= 4'd0;
            monto_q_r     <= 32'd0;
            tipo_q_r      <= 1'b0;
        end else begin
            card_q_r      <= bus.tarjeta_recibida;
            dig_q_r       <= bus.digito_stb;
            monto_stb_q_r <= bus.monto_stb;
            card_ev_r     <= bus.tarjeta_recibida & ~card_q_r;
            dig_ev_r      <= bus.digito_stb & ~dig_q_r;
            monto_ev_r    <= bus.monto_stb & ~monto_stb_q_r;
            digito_q_r    <= bus.digito;
            monto_q_r     <= bus.monto;
            tipo_q_r      <= bus.tipo_trans;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ESPERANDO_TARJETA;
            pin_r      <= 16'd0;
            cnt_r      <= 3'd0;
            att_r      <= 2'd0;
            bal_r      <= INIT_BALANCE;
            monto_l_r  <= 32'd0;
            bal_act_r  <= 1'b0;
            entregar_r <= 1'b0;
            pin_inc_r  <= 1'b0;
            adv_r      <= 1'b0;
            blq_r      <= 1'b0;
            fondos_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pin_r      <= pin_s;
            cnt_r      <= cnt_s;
            att_r      <= att_s;
            bal_r      <= bal_s;
            monto_l_r  <= monto_l_s;
            bal_act_r  <= bal_act_s;
            entregar_r <= entregar_s;
            pin_inc_r  <= pin_inc_s;
            adv_r      <= adv_s;
            blq_r      <= blq_s;
            fondos_r   <= fondos_s;
        end
    end

`ifdef ATM_TIMEOUT_EN
    // Idle-cycle counter for PIN and amount entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_r <= '0;
        end else begin
            to_r <= to_s;
        end
    end
`endif

    assign monto_ext_s = {{(BAL_W-32){1'b0}}, monto_l_r};
    assign sum_s       = {1'b0, bal_r} + {1'b0, monto_ext_s};

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        pin_s      = pin_r;
        cnt_s      = cnt_r;
        att_s      = att_r;
        bal_s      = bal_r;
        monto_l_s  = monto_l_r;
        bal_act_s  = 1'b0;
        entregar_s = 1'b0;
        pin_inc_s  = 1'b0;
        fondos_s   = 1'b0;
        adv_s      = adv_r;
        blq_s      = blq_r;
        case (state_r)
            ESPERANDO_TARJETA: begin
                if (card_ev_r) begin
                    state_s = VERIFICAR_PIN;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = ESPERANDO_TARJETA;
                end
            end
            VERIFICAR_PIN: begin
                if (cnt_r == 3'd4) begin
                    cnt_s = 3'd0;
                    if (pin_r == PIN) begin
                        att_s   = 2'd0;
                        adv_s   = 1'b0;
                        state_s = ESPERANDO_MONTO;
                    end else begin
                        pin_inc_s = 1'b1;
                        att_s     = att_r + 2'd1;
                        if (att_r == 2'd2) begin
                            state_s = BLOQUEO;
                            blq_s   = 1'b1;
                            adv_s   = 1'b1;
                        end else if (att_r == 2'd1) begin
                            adv_s = 1'b1;
                        end else begin
                            adv_s = adv_r;
                        end
                    end
                end else if (dig_ev_r) begin
                    pin_s = {pin_r[11:0], digito_q_r};
                    cnt_s = cnt_r + 3'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ESPERANDO_MONTO: begin
                if (monto_ev_r) begin
                    monto_l_s = monto_q_r;
                    state_s   = tipo_q_r ? RETIRO : DEPOSITO;
                end else begin
                    state_s = ESPERANDO_MONTO;
                end
            end
            DEPOSITO: begin
                bal_s     = sum_s[BAL_W] ? {BAL_W{1'b1}} : sum_s[BAL_W-1:0];
                bal_act_s = 1'b1;
                state_s   = ESPERANDO_TARJETA;
            end
            RETIRO: begin
                if (monto_ext_s <= bal_r) begin
                    bal_s      = bal_r - monto_ext_s;
                    bal_act_s  = 1'b1;
                    entregar_s = 1'b1;
                end else begin
                    fondos_s = 1'b1;
                end
                state_s = ESPERANDO_TARJETA;
            end
            BLOQUEO: begin
                blq_s   = 1'b1;
                adv_s   = 1'b1;
                state_s = BLOQUEO;
            end
            default: begin
                state_s = ESPERANDO_TARJETA;
            end
        endcase
`ifdef ATM_TIMEOUT_EN
        // A mismatch that moves to BLOQUEO leaves the entry states, so the timeout never overrides it.
        to_s       = '0;
        progress_s = ((state_r == VERIFICAR_PIN) && (dig_ev_r || (cnt_r == 3'd4))) ||
                     ((state_r == ESPERANDO_MONTO) && monto_ev_r);
        if (((state_r == VERIFICAR_PIN) || (state_r == ESPERANDO_MONTO)) && !progress_s) begin
            if (to_r == TO_W'(TIMEOUT_CYC - 1)) begin
                state_s = ESPERANDO_TARJETA;
                cnt_s   = 3'd0;
            end else begin
                to_s = to_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            to_s = '0;
        end
`endif
    end

    assign bus.balance_actualizado  = bal_act_r;
    assign bus.entregar_dinero      = entregar_r;
    assign bus.pin_incorrecto       = pin_inc_r;
    assign bus.advertencia          = adv_r;
    assign bus.bloqueo              = blq_r;
    assign bus.fondos_insuficientes = fondos_r;

endmodule

// File: tb/tb_atm_controller.sv
// Directed self-checking bench for atm_controller; pulse outputs are counted by a
// monitor and compared against hand-computed counts per scenario.
module tb_atm_controller;
    logic clk;
    logic rst;
    atm_controller_if bus();

    atm_controller dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_bal = 0, n_ent = 0, n_pin = 0, n_fond = 0, n_wide = 0;
    int b_bal, b_ent, b_pin, b_fond;
    logic p_bal = 1'b0, p_ent = 1'b0, p_pin = 1'b0, p_fond = 1'b0;

    // Pulse counting and pulse-width monitor.
    always @(negedge clk) begin
        if (bus.balance_actualizado)  n_bal  <= n_bal + 1;
        if (bus.entregar_dinero)      n_ent  <= n_ent + 1;
        if (bus.pin_incorrecto)       n_pin  <= n_pin + 1;
        if (bus.fondos_insuficientes) n_fond <= n_fond + 1;
        if ((bus.balance_actualizado && p_bal) || (bus.entregar_dinero && p_ent) ||
            (bus.pin_incorrecto && p_pin) || (bus.fondos_insuficientes && p_fond))
            n_wide <= n_wide + 1;
        p_bal  <= bus.balance_actualizado;
        p_ent  <= bus.entregar_dinero;
        p_pin  <= bus.pin_incorrecto;
        p_fond <= bus.fondos_insuficientes;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_bal = n_bal; b_ent = n_ent; b_pin = n_pin; b_fond = n_fond;
    endtask

    task automatic card();
        @(negedge clk); bus.tarjeta_recibida = 1'b1;
        @(negedge clk); bus.tarjeta_recibida = 1'b0;
        idle(3);
    endtask

    task automatic digit(input logic [3:0] d, input int hold);
        @(negedge clk); bus.digito = d; bus.digito_stb = 1'b1;
        repeat (hold) @(negedge clk);
        bus.digito_stb = 1'b0;
        idle(2);
    endtask

    task automatic enter_pin(input logic [15:0] p);
        digit(p[15:12], 1); digit(p[11:8], 1); digit(p[7:4], 1); digit(p[3:0], 1);
        idle(4);
    endtask

    task automatic amount(input logic tipo, input logic [31:0] m);
        @(negedge clk); bus.tipo_trans = tipo; bus.monto = m; bus.monto_stb = 1'b1;
        @(negedge clk); bus.monto_stb = 1'b0;
        idle(6);
    endtask

    task automatic session(input logic [15:0] p, input logic tipo, input logic [31:0] m);
        card(); enter_pin(p); amount(tipo, m);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        idle(2);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_outs"}, {58'd0, bus.balance_actualizado, bus.entregar_dinero,
                 bus.pin_incorrecto, bus.advertencia, bus.bloqueo, bus.fondos_insuficientes}, 64'd0);
    endtask

    // Probe balance b: b+1 is rejected, b is dispensed, then b is deposited back.
    task automatic expect_balance(input string tag, input logic [31:0] b);
        snap(); session(16'h4756, 1'b1, b + 32'd1);
        check_eq({tag, "_over_fond"}, 64'(n_fond - b_fond), 64'd1);
        check_eq({tag, "_over_ent"},  64'(n_ent - b_ent),   64'd0);
        snap(); session(16'h4756, 1'b1, b);
        check_eq({tag, "_exact_ent"}, 64'(n_ent - b_ent),   64'd1);
        check_eq({tag, "_exact_fond"}, 64'(n_fond - b_fond), 64'd0);
        session(16'h4756, 1'b0, b);
    endtask

    initial begin
        rst = 1'b0;
        bus.tarjeta_recibida = 1'b0; bus.tipo_trans = 1'b0; bus.digito_stb = 1'b0;
        bus.digito = 4'd0; bus.monto_stb = 1'b0; bus.monto = 32'd0;
        idle(3);
        rst = 1'b1;
        idle(2);
        check_outputs_zero("reset");

        // 1: deposit 10000 -> 15000
        snap(); session(16'h4756, 1'b0, 32'd10000);
        check_eq("t1_bal_pulse", 64'(n_bal - b_bal), 64'd1);
        check_eq("t1_ent_pulse", 64'(n_ent - b_ent), 64'd0);

        // 2: two wrong PINs then correct, withdraw 10000 -> 5000
        snap(); card(); enter_pin(16'h4757); enter_pin(16'h4757);
        check_eq("t2_pin_pulses", 64'(n_pin - b_pin), 64'd2);
        check_eq("t2_adv_set", {63'd0, bus.advertencia}, 64'd1);
        snap(); enter_pin(16'h4756); amount(1'b1, 32'd10000);
        check_eq("t2_bal_pulse", 64'(n_bal - b_bal), 64'd1);
        check_eq("t2_ent_pulse", 64'(n_ent - b_ent), 64'd1);
        check_eq("t2_adv_clr", {63'd0, bus.advertencia}, 64'd0);

        // 3: withdraw 10000 from 5000 rejected
        snap(); session(16'h4756, 1'b1, 32'd10000);
        check_eq("t3_fond_pulse", 64'(n_fond - b_fond), 64'd1);
        check_eq("t3_bal_pulse", 64'(n_bal - b_bal), 64'd0);

        // 4: withdraw 1000 -> 4000
        snap(); session(16'h4756, 1'b1, 32'd1000);
        check_eq("t4_ent_pulse", 64'(n_ent - b_ent), 64'd1);
        check_eq("t4_bal_pulse", 64'(n_bal - b_bal), 64'd1);

        // zero amounts are legal both ways
        snap(); session(16'h4756, 1'b1, 32'd0);
        check_eq("zero_wd_ent", 64'(n_ent - b_ent), 64'd1);
        snap(); session(16'h4756, 1'b0, 32'd0);
        check_eq("zero_dep_bal", 64'(n_bal - b_bal), 64'd1);
        expect_balance("bal4000", 32'd4000);

        // digit and amount edges ignored while waiting for a card
        snap(); digit(4'd4, 1); digit(4'd7, 1); amount(1'b1, 32'd1);
        session(16'h4756, 1'b0, 32'd3);
        check_eq("idle_ign_pin", 64'(n_pin - b_pin), 64'd0);
        check_eq("idle_ign_bal", 64'(n_bal - b_bal), 64'd1);
        check_eq("idle_ign_ent", 64'(n_ent - b_ent), 64'd0);

        // 6: digit held 3 cycles counts once
        snap(); card(); digit(4'd4, 3); digit(4'd7, 1); digit(4'd5, 1); digit(4'd6, 1);
        idle(4); amount(1'b0, 32'd5);
        check_eq("hold_pin", 64'(n_pin - b_pin), 64'd0);
        check_eq("hold_bal", 64'(n_bal - b_bal), 64'd1);

        // 6: reset after two digits aborts silently
        snap(); card(); digit(4'd4, 1); digit(4'd7, 1);
        do_reset();
        check_eq("rst_mid_pulses", 64'((n_bal - b_bal) + (n_ent - b_ent) + (n_pin - b_pin) + (n_fond - b_fond)), 64'd0);
        check_outputs_zero("rst_mid");
        expect_balance("bal_rst", 32'd5000);

        // 5: three wrong PINs lock the account
        snap(); card(); enter_pin(16'h4757); enter_pin(16'h4757); enter_pin(16'h4757);
        check_eq("lock_pin_pulses", 64'(n_pin - b_pin), 64'd3);
        check_eq("lock_bloqueo", {63'd0, bus.bloqueo}, 64'd1);
        check_eq("lock_adv", {63'd0, bus.advertencia}, 64'd1);
        snap(); session(16'h4756, 1'b1, 32'd100); enter_pin(16'h4757);
        check_eq("lock_ign", 64'((n_bal - b_bal) + (n_ent - b_ent) + (n_pin - b_pin) + (n_fond - b_fond)), 64'd0);
        check_eq("lock_held", {63'd0, bus.bloqueo}, 64'd1);
        do_reset();
        check_outputs_zero("lock_rst");
        expect_balance("bal_lock", 32'd5000);

        // long idle during PIN entry
        snap(); card(); digit(4'd4, 1); digit(4'd7, 1);
        idle(300);
`ifdef ATM_TIMEOUT_EN
        card(); enter_pin(16'h4756);
`else
        digit(4'd5, 1); digit(4'd6, 1); idle(4);
`endif
        amount(1'b0, 32'd7);
        check_eq("idle_long_bal", 64'(n_bal - b_bal), 64'd1);
        check_eq("idle_long_pin", 64'(n_pin - b_pin), 64'd0);

        check_eq("pulse_width", 64'(n_wide), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
